// File: rtl/dac_spi_multi.sv
// Round-robin SPI write engine for a bank of AD568x-class DACs sharing SCLK/MOSI.
// Each channel is resent whenever its code differs from the last one sent, or when it is forced.
module dac_spi_multi #(
  parameter int NCH     = 4,
  parameter int DW      = 16,
  parameter int CLK_DIV = 8,
  parameter int GAP     = 4,
  parameter int SIM_UPD = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NCH*DW-1:0] dat,
  input  logic              refresh,
  output logic              sclk,
  output logic              mosi,
  output logic [NCH-1:0]    sync_n,
  output logic              ldac_n,
  output logic              busy,
  output logic              done
);

  localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int CW = $clog2(2 * CLK_DIV + GAP + 1);
  localparam logic [CW-1:0] DIV_LAST  = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(GAP - 1);
  localparam logic [CW-1:0] LDAC_LAST = CW'(2 * CLK_DIV - 1);
  localparam logic [3:0]    CMD       = (SIM_UPD != 0) ? 4'b0001 : 4'b0011;
  localparam logic [4:0]    LAST_BIT  = 5'd23;

  typedef enum logic [2:0] {
    IDLE, SETUP, SHIFT_LO, SHIFT_HI, HOLD, GAP_W, LDAC, LDAC_GAP
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [4:0]      bit_cnt;
  logic [23:0]     shreg;
  logic [DW-1:0]   snap;
  logic [PW-1:0]   cur;
  logic [PW-1:0]   ptr;
  logic            sweep_wr;
  logic [DW-1:0]   last [NCH];
  logic [NCH-1:0]  force_q;

  logic [NCH-1:0]  pend;
  logic            any_pend;
  logic            fwd_ok;
  logic [PW-1:0]   sel_fwd;
  logic [PW-1:0]   sel_any;
  logic [PW-1:0]   sel;
  logic [DW-1:0]   sel_code;
  logic [15:0]     code16;

  // Lowest pending channel at or above ptr, otherwise the lowest pending one overall.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    pend    = '0;
    fwd_ok  = 1'b0;
    sel_fwd = '0;
    sel_any = '0;
    for (int k = 0; k < NCH; k++) begin
      pend[k] = (dat[k*DW +: DW] != last[k]) || force_q[k];
    end
    for (int k = NCH - 1; k >= 0; k--) begin
      if (pend[k]) begin
        sel_any = PW'(k);
        if (k >= int'(ptr)) begin
          sel_fwd = PW'(k);
          fwd_ok  = 1'b1;
        end
      end
    end
    any_pend = |pend;
    sel      = fwd_ok ? sel_fwd : sel_any;
    sel_code = dat[sel*DW +: DW];
    code16   = 16'(sel_code) << (16 - DW);
  end

  // NOTE: all state below uses non-blocking assignments, so every branch reads pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      snap     <= '0;
      cur      <= '0;
      ptr      <= '0;
      sweep_wr <= 1'b0;
      force_q  <= '1;
      // NOTE: last[] is a small register bank, not RAM; it is reset so pending detection starts from code 0.
      for (int k = 0; k < NCH; k++) last[k] <= '0;
      sclk     <= 1'b1;
      mosi     <= 1'b0;
      sync_n   <= '1;
      ldac_n   <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (any_pend) begin
            cur     <= sel;
            snap    <= sel_code;
            shreg   <= {CMD, code16, 4'b0000};
            mosi    <= CMD[3];
            sync_n  <= ~(NCH'(1) << sel);
            busy    <= 1'b1;
            cnt     <= '0;
            bit_cnt <= '0;
            state   <= SETUP;
          end
        end
        SETUP: begin
          if (cnt == DIV_LAST) begin
            cnt   <= '0;
            sclk  <= 1'b0;
            state <= SHIFT_LO;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        // Data advances on the rising edge so it is stable a full half-period around each falling edge.
        SHIFT_LO: begin
          if (cnt == DIV_LAST) begin
            cnt   <= '0;
            sclk  <= 1'b1;
            state <= SHIFT_HI;
            if (bit_cnt != LAST_BIT) begin
              shreg <= shreg << 1;
              mosi  <= shreg[22];
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        SHIFT_HI: begin
          if (cnt == DIV_LAST) begin
            cnt <= '0;
            if (bit_cnt != LAST_BIT) begin
              bit_cnt <= bit_cnt + 1'b1;
              sclk    <= 1'b0;
              state   <= SHIFT_LO;
            end else begin
              state <= HOLD;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        HOLD: begin
          if (cnt == DIV_LAST) begin
            cnt          <= '0;
            sync_n       <= '1;
            mosi         <= 1'b0;
            done         <= 1'b1;
            last[cur]    <= snap;
            force_q[cur] <= 1'b0;
            ptr          <= (cur == PW'(NCH - 1)) ? '0 : cur + 1'b1;
            sweep_wr     <= 1'b1;
            state        <= GAP_W;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        GAP_W: begin
          if (cnt == GAP_LAST) begin
            cnt <= '0;
            if ((SIM_UPD != 0) && sweep_wr && ((ptr == '0) || !fwd_ok)) begin
              ldac_n <= 1'b0;
              state  <= LDAC;
            end else begin
              busy  <= 1'b0;
              state <= IDLE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        LDAC: begin
          if (cnt == LDAC_LAST) begin
            cnt      <= '0;
            ldac_n   <= 1'b1;
            sweep_wr <= 1'b0;
            state    <= LDAC_GAP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        LDAC_GAP: begin
          if (cnt == GAP_LAST) begin
            cnt   <= '0;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
      // A refresh in the same cycle as a frame-end clear must win.
      if (refresh) force_q <= '1;
    end
  end

endmodule

// File: tb/tb_dac_spi_multi.sv
// Bench for dac_spi_multi: three configurations decoded at the pins and checked against a
// frame-level model (last code sent, force flags, round-robin pointer).
module tb_dac_spi_multi;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]  rst_v = 3'b111;
  logic [2:0]  ref_v = 3'b000;
  logic [2:0]  sclk_v, mosi_v, ldac_v, busy_v, done_v;
  logic [1:0]  sync_a;
  logic [2:0]  sync_b;
  logic [3:0]  sync_c;
  logic [31:0] dat_a;
  logic [35:0] dat_b;
  logic [63:0] dat_c;
  logic [7:0]  sync8 [3];

  int nch_p [3] = '{2, 3, 4};
  int dw_p  [3] = '{16, 12, 16};
  int div_p [3] = '{8, 8, 1};
  int gap_p [3] = '{4, 4, 2};
  int sim_p [3] = '{0, 1, 0};

  // Stimulus codes and frame-level reference model
  logic [15:0] dm     [3][8];
  logic [15:0] last_m [3][8];
  logic        force_m[3][8];
  int          ptr_m  [3];

  // Pin decoder state
  logic        in_frame [3];
  int          fch [3], flow [3], fedges [3], fbad [3], hi_cnt [3];
  logic [23:0] fword [3], fexp [3];
  logic [15:0] fcode [3];
  logic        fbit [3], prev_sclk [3], prev_mosi [3], prev_ldac [3];
  logic [26:0] flog [3][256];
  int          fcnt [3];
  int          ldac_low [3], ldac_pulses [3], ldac_len [3], ldac_cur [3], ldac_delay [3], rise_cyc [3];
  int          cyc = 0;

  int n_checks = 0;
  int n_errs   = 0;

  dac_spi_multi #(.NCH(2), .DW(16), .CLK_DIV(8), .GAP(4), .SIM_UPD(0)) u_a (
    .clk(clk), .rst(rst_v[0]), .dat(dat_a), .refresh(ref_v[0]), .sclk(sclk_v[0]), .mosi(mosi_v[0]),
    .sync_n(sync_a), .ldac_n(ldac_v[0]), .busy(busy_v[0]), .done(done_v[0]));

  dac_spi_multi #(.NCH(3), .DW(12), .CLK_DIV(8), .GAP(4), .SIM_UPD(1)) u_b (
    .clk(clk), .rst(rst_v[1]), .dat(dat_b), .refresh(ref_v[1]), .sclk(sclk_v[1]), .mosi(mosi_v[1]),
    .sync_n(sync_b), .ldac_n(ldac_v[1]), .busy(busy_v[1]), .done(done_v[1]));

  dac_spi_multi #(.NCH(4), .DW(16), .CLK_DIV(1), .GAP(2), .SIM_UPD(0)) u_c (
    .clk(clk), .rst(rst_v[2]), .dat(dat_c), .refresh(ref_v[2]), .sclk(sclk_v[2]), .mosi(mosi_v[2]),
    .sync_n(sync_c), .ldac_n(ldac_v[2]), .busy(busy_v[2]), .done(done_v[2]));

  always_comb begin
    dat_a    = {dm[0][1], dm[0][0]};
    dat_b    = {dm[1][2][11:0], dm[1][1][11:0], dm[1][0][11:0]};
    dat_c    = {dm[2][3], dm[2][2], dm[2][1], dm[2][0]};
    sync8[0] = {6'h3F, sync_a};
    sync8[1] = {5'h1F, sync_b};
    sync8[2] = {4'hF, sync_c};
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic pending(input int d, input int k);
    return (dm[d][k] != last_m[d][k]) || force_m[d][k];
  endfunction

  function automatic logic pending_any(input int d);
    for (int k = 0; k < nch_p[d]; k++) if (pending(d, k)) return 1'b1;
    return 1'b0;
  endfunction

  // Round robin: first pending channel at or after the pointer, wrapping once.
  function automatic int exp_sel(input int d);
    for (int i = 0; i < nch_p[d]; i++) begin
      int k;
      k = (ptr_m[d] + i) % nch_p[d];
      if (pending(d, k)) return k;
    end
    return -1;
  endfunction

  function automatic logic [23:0] frame_word(input int d, input logic [15:0] code);
    logic [15:0] c16;
    c16 = code << (16 - dw_p[d]);
    return {(sim_p[d] != 0) ? 4'h1 : 4'h3, c16, 4'h0};
  endfunction

  task automatic model_reset(input int d);
    for (int k = 0; k < 8; k++) begin
      last_m[d][k]  = '0;
      force_m[d][k] = 1'b1;
    end
    ptr_m[d]     = 0;
    in_frame[d]  = 1'b0;
    hi_cnt[d]    = 100;
    prev_sclk[d] = 1'b1;
    prev_mosi[d] = 1'b0;
  endtask

  task automatic mon(input int d);
    logic [7:0] sn;
    logic       sck, mo, dn, ld;
    int         nlow, ch;
    sn  = sync8[d];
    sck = sclk_v[d];
    mo  = mosi_v[d];
    dn  = done_v[d];
    ld  = ldac_v[d];
    if (!ld) begin
      ldac_low[d]++;
      if (prev_ldac[d]) begin
        ldac_pulses[d]++;
        ldac_delay[d] = cyc - rise_cyc[d];
        ldac_cur[d]   = 0;
      end
      ldac_cur[d]++;
    end else if (!prev_ldac[d]) begin
      ldac_len[d] = ldac_cur[d];
    end
    prev_ldac[d] = ld;
    if (rst_v[d]) begin
      model_reset(d);
      return;
    end
    nlow = 0;
    ch   = 0;
    for (int k = 0; k < nch_p[d]; k++) begin
      if (!sn[k]) begin
        nlow++;
        ch = k;
      end
    end
    if (!in_frame[d]) begin
      if (dn) check($sformatf("d%0d_done_spurious", d), 32'(dn), 32'd0);
      if (nlow != 0) begin
        check($sformatf("d%0d_one_sync_low", d), 32'(nlow), 32'd1);
        check($sformatf("d%0d_rr_select", d), 32'(ch), 32'(exp_sel(d)));
        check($sformatf("d%0d_gap_ge", d), 32'(hi_cnt[d] >= gap_p[d] + 1), 32'd1);
        in_frame[d] = 1'b1;
        fch[d]      = ch;
        flow[d]     = 1;
        fedges[d]   = 0;
        fbad[d]     = 0;
        fword[d]    = '0;
        fbit[d]     = mo;
        fcode[d]    = dm[d][ch];
        fexp[d]     = frame_word(d, dm[d][ch]);
      end else begin
        hi_cnt[d]++;
      end
    end else if (!sn[fch[d]]) begin
      flow[d]++;
      if (dn) check($sformatf("d%0d_done_spurious", d), 32'(dn), 32'd0);
      if (nlow != 1) fbad[d]++;
      if (prev_sclk[d] && !sck) begin
        fword[d] = {fword[d][22:0], mo};
        fedges[d]++;
        fbit[d] = mo;
        if (mo != prev_mosi[d]) fbad[d]++;
      end else if (!sck && mo != fbit[d]) begin
        fbad[d]++;
      end
    end else begin
      check($sformatf("d%0d_sync_low_len", d), 32'(flow[d]), 32'(50 * div_p[d]));
      check($sformatf("d%0d_fall_edges", d), 32'(fedges[d]), 32'd24);
      check($sformatf("d%0d_frame_word", d), 32'(fword[d]), 32'(fexp[d]));
      check($sformatf("d%0d_done_at_end", d), 32'(dn), 32'd1);
      check($sformatf("d%0d_idle_lines", d), {30'd0, sck, mo}, 32'd2);
      check($sformatf("d%0d_mosi_stable", d), 32'(fbad[d]), 32'd0);
      if (fcnt[d] < 256) flog[d][fcnt[d]] = {3'(fch[d]), fword[d]};
      fcnt[d]++;
      last_m[d][fch[d]]  = fcode[d];
      force_m[d][fch[d]] = 1'b0;
      ptr_m[d]    = (fch[d] + 1) % nch_p[d];
      in_frame[d] = 1'b0;
      hi_cnt[d]   = 1;
      rise_cyc[d] = cyc;
    end
    if (ref_v[d]) for (int k = 0; k < 8; k++) force_m[d][k] = 1'b1;
    prev_sclk[d] = sck;
    prev_mosi[d] = mo;
  endtask

  always @(posedge clk) begin
    #1;
    cyc++;
    for (int d = 0; d < 3; d++) mon(d);
  end

  task automatic wait_quiet(input int d, input int budget);
    int q = 0;
    int n = 0;
    while (q < 4 && n < budget) begin
      @(negedge clk);
      n++;
      if (!busy_v[d] && !in_frame[d] && !pending_any(d)) q++;
      else q = 0;
    end
    if (q < 4) check($sformatf("d%0d_quiet_timeout", d), 32'd0, 32'd1);
  endtask

  task automatic pulse_refresh(input int d);
    @(negedge clk);
    ref_v[d] = 1'b1;
    @(negedge clk);
    ref_v[d] = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag, input int d);
    check({tag, "_sclk"},   32'(sclk_v[d]), 32'd1);
    check({tag, "_mosi"},   32'(mosi_v[d]), 32'd0);
    check({tag, "_sync_n"}, 32'(sync8[d]),  32'hFF);
    check({tag, "_busy"},   32'(busy_v[d]), 32'd0);
    check({tag, "_done"},   32'(done_v[d]), 32'd0);
    check({tag, "_ldac_n"}, 32'(ldac_v[d]), 32'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", n_errs + 1, n_checks + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int n, p, budget;
    for (int d = 0; d < 3; d++) begin
      for (int k = 0; k < 8; k++) dm[d][k] = '0;
      model_reset(d);
      fcnt[d] = 0; ldac_low[d] = 0; ldac_pulses[d] = 0; ldac_len[d] = 0;
      ldac_cur[d] = 0; ldac_delay[d] = 0; rise_cyc[d] = 0; prev_ldac[d] = 1'b1;
    end
    dm[0][0] = 16'h1234;
    dm[0][1] = 16'h8000;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) check_reset_outputs($sformatf("d%0d_reset", d), d);
    rst_v = 3'b000;

    // Post-reset sweep: every channel written once
    wait_quiet(0, 3000);
    wait_quiet(1, 4000);
    wait_quiet(2, 1000);
    check("a_init_count", 32'(fcnt[0]), 32'd2);
    check("a_init_ch0", 32'(flog[0][0]), {5'd0, 3'd0, 24'h312340});
    check("a_init_ch1", 32'(flog[0][1]), {5'd0, 3'd1, 24'h380000});
    check("b_init_count", 32'(fcnt[1]), 32'd3);
    check("b_init_ch2", 32'(flog[1][2]), {5'd0, 3'd2, 24'h100000});
    check("b_init_ldac_pulses", 32'(ldac_pulses[1]), 32'd1);
    check("c_init_count", 32'(fcnt[2]), 32'd4);

    // All four channels of C change together: order 0..3
    n = fcnt[2];
    @(negedge clk);
    dm[2][0] = 16'h1111; dm[2][1] = 16'h2222; dm[2][2] = 16'h3333; dm[2][3] = 16'h4444;
    wait_quiet(2, 1000);
    check("c_burst_count", 32'(fcnt[2] - n), 32'd4);
    for (int i = 0; i < 4; i++)
      check($sformatf("c_burst_%0d", i), 32'(flog[2][n + i]),
            {5'd0, 3'(i), 4'h3, dm[2][i], 4'h0});

    // Constant codes: no activity
    n = fcnt[0];
    p = 0;
    repeat (10000) begin
      @(negedge clk);
      p += int'(busy_v[0]) + int'(!sync8[0][0]) + int'(!sync8[0][1]);
    end
    check("a_quiet_frames", 32'(fcnt[0]), 32'(n));
    check("a_quiet_activity", 32'(p), 32'd0);

    // Refresh rewrites both channels identically
    n = fcnt[0];
    pulse_refresh(0);
    wait_quiet(0, 3000);
    check("a_refresh_count", 32'(fcnt[0] - n), 32'd2);
    check("a_refresh_ch0", 32'(flog[0][n]), {5'd0, 3'd0, 24'h312340});
    check("a_refresh_ch1", 32'(flog[0][n + 1]), {5'd0, 3'd1, 24'h380000});

    // ch0 changes mid-frame: old code goes out, new code follows after ch1
    n = fcnt[0];
    pulse_refresh(0);
    budget = 0;
    while (!(in_frame[0] && fch[0] == 0 && fedges[0] >= 5) && budget < 2000) begin
      @(negedge clk);
      budget++;
    end
    check("a_midframe_reached", 32'(budget < 2000), 32'd1);
    dm[0][0] = 16'hFFFF;
    wait_quiet(0, 4000);
    check("a_mid_count", 32'(fcnt[0] - n), 32'd3);
    check("a_mid_old", 32'(flog[0][n]), {5'd0, 3'd0, 24'h312340});
    check("a_mid_ch1", 32'(flog[0][n + 1]), {5'd0, 3'd1, 24'h380000});
    check("a_mid_new", 32'(flog[0][n + 2]), {5'd0, 3'd0, 24'h3FFFF0});

    // Simultaneous-update mode: one frame, then exactly one LDAC pulse
    n = fcnt[1];
    p = ldac_pulses[1];
    @(negedge clk);
    dm[1][2] = 16'h0ABC;
    wait_quiet(1, 2000);
    check("b_abc_count", 32'(fcnt[1] - n), 32'd1);
    check("b_abc_frame", 32'(flog[1][n]), {5'd0, 3'd2, 24'h1ABC00});
    check("b_ldac_pulses", 32'(ldac_pulses[1] - p), 32'd1);
    check("b_ldac_len", 32'(ldac_len[1]), 32'd16);
    check("b_ldac_delay", 32'(ldac_delay[1]), 32'd4);

    // Random code churn and refreshes on A and C, judged by the model
    repeat (4000) begin
      @(negedge clk);
      for (int d = 0; d < 3; d += 2) begin
        ref_v[d] = ($urandom_range(0, 799) == 0);
        if ($urandom_range(0, 59) == 0)
          dm[d][$urandom_range(0, nch_p[d] - 1)] = 16'($urandom);
      end
    end
    @(negedge clk);
    ref_v = 3'b000;
    wait_quiet(0, 20000);
    wait_quiet(2, 5000);

    // Reset mid-frame aborts cleanly; then both channels are rewritten from ch0
    @(negedge clk);
    dm[0][0] = 16'h5A5A;
    dm[0][1] = 16'h0F0F;
    budget = 0;
    while (!(in_frame[0] && fedges[0] >= 11) && budget < 2000) begin
      @(negedge clk);
      budget++;
    end
    check("a_bit10_reached", 32'(budget < 2000), 32'd1);
    rst_v[0] = 1'b1;
    @(posedge clk);
    #2;
    check("a_abort_sclk", 32'(sclk_v[0]), 32'd1);
    check("a_abort_sync_n", 32'(sync8[0]), 32'hFF);
    check("a_abort_mosi", 32'(mosi_v[0]), 32'd0);
    check("a_abort_busy", 32'(busy_v[0]), 32'd0);
    @(negedge clk);
    rst_v[0] = 1'b0;
    n = fcnt[0];
    wait_quiet(0, 3000);
    check("a_after_rst_count", 32'(fcnt[0] - n), 32'd2);
    check("a_after_rst_ch0", 32'(flog[0][n]), {5'd0, 3'd0, 24'h35A5A0});
    check("a_after_rst_ch1", 32'(flog[0][n + 1]), {5'd0, 3'd1, 24'h30F0F0});

    check("a_ldac_idle", 32'(ldac_low[0]), 32'd0);
    check("c_ldac_idle", 32'(ldac_low[2]), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
